// File: rtl/perceptron_trainer_pkg.sv
// Shared types and weight-word packing for the perceptron trainer.
// Word layout: [95:60] 3-bit HOBs, [59:0] 5-bit LOBs, weight i = {HOB i, LOB i}.
package perceptron_trainer_pkg;
   localparam int WT_W   = 8;
   localparam int HOB_W  = 3;
   localparam int LOB_W  = 5;
   localparam int NUM_WT = 12;
   localparam int WORD_W = NUM_WT * WT_W;

   typedef enum logic {ST_INIT, ST_RUN} state_e;
   typedef logic [NUM_WT-1:0][WT_W-1:0] wvec_t;

   function automatic wvec_t unpack_w(input logic [WORD_W-1:0] word);
      wvec_t v;
      for (int i = 0; i < NUM_WT; i++)
         v[i] = {word[NUM_WT*LOB_W + HOB_W*i +: HOB_W], word[LOB_W*i +: LOB_W]};
      return v;
   endfunction

   function automatic logic [WORD_W-1:0] pack_w(input wvec_t v);
      logic [WORD_W-1:0] word;
      word = '0;
      for (int i = 0; i < NUM_WT; i++) begin
         word[NUM_WT*LOB_W + HOB_W*i +: HOB_W] = v[i][WT_W-1:LOB_W];
         word[LOB_W*i +: LOB_W]                = v[i][LOB_W-1:0];
      end
      return word;
   endfunction
endpackage

// File: rtl/perceptron_trainer_weight_update.sv
// Single-weight saturating +/-1 step; passes the weight through when not training.
module pt_weight_update
   import perceptron_trainer_pkg::*;
(
   input  logic [WT_W-1:0] w_in,
   input  logic            inc,
   input  logic            en,
   output logic [WT_W-1:0] w_out
);
   always_comb begin
      w_out = w_in;
      if (en) begin
         if (inc) begin
            if (w_in != 8'h7F) w_out = w_in + 8'd1;
         end else begin
            if (w_in != 8'h80) w_out = w_in - 8'd1;
         end
      end
   end
endmodule

// File: rtl/perceptron_trainer.sv
// Two-stage perceptron training pipeline with post-reset table clear sweep.
// Optional PT_BYPASS_EN forwards in-flight weight words to same-index branches.
module perceptron_trainer
   import perceptron_trainer_pkg::*;
#(
   parameter int ENTRIES  = 64,
   parameter int IDX_W    = 6,
   parameter int GHR_SIZE = 12,
   parameter int THETA    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ex_valid,
   input  logic [31:0]       ex_pc,
   input  logic [95:0]       ex_weights,
   input  logic [11:0]       ex_ghr,
   input  logic [7:0]        ex_sum,
   input  logic              ex_dir,
   input  logic              ex_pred_dir,
   input  logic              stall,
   output logic              in_ready,
   output logic              up_valid,
   output logic              up_wen,
   output logic [IDX_W-1:0]  up_index,
   output logic [95:0]       up_data,
   output logic              up_dir,
   output logic              up_miss,
   output logic              init_done,
   output logic [31:0]       train_count
);
   state_e state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [31:0] tc_q, tc_d;

   logic s1_valid_q, s1_valid_d, s1_dir_q, s1_dir_d, s1_pred_q, s1_pred_d;
   logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
   logic [95:0] s1_w_q, s1_w_d;
   logic [11:0] s1_ghr_q, s1_ghr_d;
   logic [7:0] s1_sum_q, s1_sum_d;

   logic o_valid_q, o_valid_d, o_wen_q, o_wen_d, o_dir_q, o_dir_d, o_miss_q, o_miss_d;
   logic [IDX_W-1:0] o_idx_q, o_idx_d;
   logic [95:0] o_data_q, o_data_d;

   logic run, accept, s2_miss, s2_train;
   logic [IDX_W-1:0] ex_idx;
   logic [8:0] s2_sum9, s2_abs;
   logic [95:0] src_w, s2_word;
   wvec_t s1_wv, s2_new_wv;
   logic unused_pc;

   assign ex_idx    = ex_pc[IDX_W+1:2];
   assign unused_pc = ^{ex_pc[31:IDX_W+2], ex_pc[1:0]};
   assign run       = (state_q == ST_RUN);
   assign in_ready  = run & ~stall & ~reset;
   assign accept    = ex_valid & in_ready;

   // Stage 2: learning rule on the registered snapshot.
   assign s2_miss  = s1_dir_q ^ s1_pred_q;
   assign s2_sum9  = {s1_sum_q[7], s1_sum_q};
   assign s2_abs   = s2_sum9[8] ? (~s2_sum9 + 9'd1) : s2_sum9;
   assign s2_train = s2_miss | (s2_abs <= 9'(THETA));
   assign s1_wv    = unpack_w(s1_w_q);
   assign s2_word  = pack_w(s2_new_wv);

   for (genvar g = 0; g < GHR_SIZE; g++) begin : g_wt
      pt_weight_update u_wu (
         .w_in  (s1_wv[g]),
         .inc   (s1_dir_q == s1_ghr_q[g]),
         .en    (s2_train),
         .w_out (s2_new_wv[g])
      );
   end

`ifdef PT_BYPASS_EN
   // One-entry record of the newest trained word, loaded as it enters the output stage.
   logic last_vld_q, last_vld_d;
   logic [IDX_W-1:0] last_idx_q, last_idx_d;
   logic [95:0] last_data_q, last_data_d;

   always_comb begin
      last_vld_d  = last_vld_q;
      last_idx_d  = last_idx_q;
      last_data_d = last_data_q;
      if (!stall && s1_valid_q && s2_train) begin
         last_vld_d  = 1'b1;
         last_idx_d  = s1_idx_q;
         last_data_d = s2_word;
      end
      src_w = ex_weights;
      if (s1_valid_q && s2_train && s1_idx_q == ex_idx) src_w = s2_word;
      else if (last_vld_q && last_idx_q == ex_idx)       src_w = last_data_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_vld_q  <= 1'b0;
         last_idx_q  <= '0;
         last_data_q <= '0;
      end else begin
         last_vld_q  <= last_vld_d;
         last_idx_q  <= last_idx_d;
         last_data_q <= last_data_d;
      end
   end
`else
   assign src_w = ex_weights;
`endif

   always_comb begin
      state_d = state_q;  cnt_d = cnt_q;  tc_d = tc_q;
      s1_valid_d = s1_valid_q;  s1_idx_d = s1_idx_q;  s1_w_d = s1_w_q;
      s1_ghr_d = s1_ghr_q;  s1_sum_d = s1_sum_q;  s1_dir_d = s1_dir_q;  s1_pred_d = s1_pred_q;
      o_valid_d = o_valid_q;  o_wen_d = o_wen_q;  o_idx_d = o_idx_q;
      o_data_d = o_data_q;  o_dir_d = o_dir_q;  o_miss_d = o_miss_q;
      if (!stall) begin
         if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(ENTRIES-1)) state_d = ST_RUN;
         end
         s1_valid_d = accept;
         if (accept) begin
            s1_idx_d  = ex_idx;
            s1_w_d    = src_w;
            s1_ghr_d  = ex_ghr;
            s1_sum_d  = ex_sum;
            s1_dir_d  = ex_dir;
            s1_pred_d = ex_pred_dir;
         end
         o_valid_d = s1_valid_q;
         o_wen_d   = s1_valid_q & s2_train;
         if (s1_valid_q) begin
            o_idx_d  = s1_idx_q;
            o_data_d = s2_word;
            o_dir_d  = s1_dir_q;
            o_miss_d = s2_miss;
         end
         if (run && o_wen_q) tc_d = tc_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_INIT;  cnt_q <= '0;  tc_q <= '0;
         s1_valid_q <= 1'b0;  s1_idx_q <= '0;  s1_w_q <= '0;
         s1_ghr_q <= '0;  s1_sum_q <= '0;  s1_dir_q <= 1'b0;  s1_pred_q <= 1'b0;
         o_valid_q <= 1'b0;  o_wen_q <= 1'b0;  o_idx_q <= '0;
         o_data_q <= '0;  o_dir_q <= 1'b0;  o_miss_q <= 1'b0;
      end else begin
         state_q <= state_d;  cnt_q <= cnt_d;  tc_q <= tc_d;
         s1_valid_q <= s1_valid_d;  s1_idx_q <= s1_idx_d;  s1_w_q <= s1_w_d;
         s1_ghr_q <= s1_ghr_d;  s1_sum_q <= s1_sum_d;  s1_dir_q <= s1_dir_d;  s1_pred_q <= s1_pred_d;
         o_valid_q <= o_valid_d;  o_wen_q <= o_wen_d;  o_idx_q <= o_idx_d;
         o_data_q <= o_data_d;  o_dir_q <= o_dir_d;  o_miss_q <= o_miss_d;
      end
   end

   // Outputs are suppressed while stalled or in reset, so a held result reappears once stall drops.
   assign up_valid    = run & o_valid_q & ~stall & ~reset;
   assign up_wen      = run ? (o_wen_q & ~stall & ~reset) : (~stall & ~reset);
   assign up_index    = run ? o_idx_q  : cnt_q;
   assign up_data     = run ? o_data_q : '0;
   assign up_dir      = o_dir_q;
   assign up_miss     = o_miss_q;
   assign init_done   = run;
   assign train_count = tc_q;
endmodule
